// File: rtl/rgb_pattern_gen.sv
// Framed RGB888 test-pattern source: colour bars, gradient, checkerboard, solid.
// Optional frame-id stamp on pixel (0,0): define RGB_PATTERN_FRAME_ID_EN.
module rgb_pattern_gen #(
   parameter int          H_ACTIVE  = 720,
   parameter int          V_ACTIVE  = 480,
   parameter int          H_BLANK   = 16,
   parameter int          V_BLANK   = 64,
   parameter int          CHK_LOG2  = 3,
   parameter logic [23:0] SOLID_RGB = 24'h0080FF
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  mode,
   input  logic        continuous,
   output logic        rgb_de,
   output logic [23:0] rgb_data,
   output logic        frame_done,
   output logic        busy,
   output logic [15:0] frame_cnt
);

   localparam int BAR_W = H_ACTIVE / 8;
   localparam int M1    = (H_ACTIVE > H_BLANK) ? H_ACTIVE : H_BLANK;
   localparam int CMAX  = (M1 > V_BLANK + 1) ? M1 : V_BLANK + 1;
   localparam int CW    = $clog2(CMAX + 1);
   localparam int VW    = $clog2(V_ACTIVE + 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

   state_t        st, n_st;
   logic [CW-1:0] h, n_h;
   logic [VW-1:0] v, n_v;
   logic [CW-1:0] bc, n_bc;
   logic [2:0]    bi, n_bi;
   logic [1:0]    mode_q, n_mode;
   logic          done_n, restart, de_n, cx, cy;
   logic [15:0]   cnt_n;
   logic [7:0]    gx;
   logic [23:0]   pix, bar_rgb;

   always_comb begin
      n_st    = st;
      n_h     = h;
      n_v     = v;
      n_bc    = bc;
      n_bi    = bi;
      n_mode  = mode_q;
      done_n  = 1'b0;
      cnt_n   = frame_cnt;
      restart = 1'b0;
      case (st)
         IDLE: restart = start;
         ACTIVE: begin
            if (h == CW'(H_ACTIVE - 1)) begin
               n_st = HBLANK;
               n_h  = '0;
            end else begin
               n_h = h + CW'(1);
            end
            // bar index saturates so the last bar absorbs the remainder
            if (bc == CW'(BAR_W - 1)) begin
               n_bc = '0;
               if (bi != 3'd7) n_bi = bi + 3'd1;
            end else begin
               n_bc = bc + CW'(1);
            end
         end
         HBLANK: begin
            if (h == CW'(H_BLANK - 1)) begin
               n_h  = '0;
               n_bc = '0;
               n_bi = '0;
               if (v < VW'(V_ACTIVE - 1)) begin
                  n_v  = v + VW'(1);
                  n_st = ACTIVE;
               end else begin
                  n_st = VBLANK;
               end
            end else begin
               n_h = h + CW'(1);
            end
         end
         VBLANK: begin
            // count V_BLANK idle cycles, then one extra cycle carrying frame_done
            if (h == CW'(V_BLANK)) begin
               n_h = '0;
               if (continuous) restart = 1'b1;
               else            n_st    = IDLE;
            end else begin
               n_h = h + CW'(1);
               if (h == CW'(V_BLANK - 1)) begin
                  done_n = 1'b1;
                  cnt_n  = frame_cnt + 16'd1;
               end
            end
         end
         default: n_st = IDLE;
      endcase
      if (restart) begin
         n_st   = ACTIVE;
         n_h    = '0;
         n_v    = '0;
         n_bc   = '0;
         n_bi   = '0;
         n_mode = mode;
      end
   end

   always_comb begin
      case (n_bi)
         3'd0:    bar_rgb = 24'hFFFFFF;
         3'd1:    bar_rgb = 24'hFFFF00;
         3'd2:    bar_rgb = 24'h00FFFF;
         3'd3:    bar_rgb = 24'h00FF00;
         3'd4:    bar_rgb = 24'hFF00FF;
         3'd5:    bar_rgb = 24'hFF0000;
         3'd6:    bar_rgb = 24'h0000FF;
         default: bar_rgb = 24'h000000;
      endcase
      gx   = 8'(n_h);
      cx   = ((32'(n_h) >> CHK_LOG2) & 32'd1) != 32'd0;
      cy   = ((32'(n_v) >> CHK_LOG2) & 32'd1) != 32'd0;
      de_n = (n_st == ACTIVE);
      case (n_mode)
         2'd0:    pix = bar_rgb;
         2'd1:    pix = {gx, gx, gx};
         2'd2:    pix = (cx ^ cy) ? 24'hFFFFFF : 24'h000000;
         default: pix = SOLID_RGB;
      endcase
`ifdef RGB_PATTERN_FRAME_ID_EN
      if (n_h == '0 && n_v == '0) pix = {8'hA5, frame_cnt};
`endif
      if (!de_n) pix = '0;
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         st         <= IDLE;
         h          <= '0;
         v          <= '0;
         bc         <= '0;
         bi         <= '0;
         mode_q     <= '0;
         rgb_de     <= 1'b0;
         rgb_data   <= '0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         st         <= n_st;
         h          <= n_h;
         v          <= n_v;
         bc         <= n_bc;
         bi         <= n_bi;
         mode_q     <= n_mode;
         rgb_de     <= de_n;
         rgb_data   <= pix;
         frame_done <= done_n;
         busy       <= (n_st != IDLE);
         frame_cnt  <= cnt_n;
      end
   end

endmodule
